// File: rtl/gpr_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// gpr_scoreboard_pkg
// Shared types and constants for the GPR/CR/SPR hazard scoreboard.
//   NUM_GPR / GPR_IDX_W : general purpose register file size and index width
//   NUM_CR              : number of condition register fields tracked
//   DEF_CNT_W           : default width of the stall-cycle counter
//   reg_index_t         : GPR index type
//   sb_state_e          : scoreboard control state (run / drain)
//   SPR_* / NUM_SPR     : bit positions of CTR, LNK and XER in the SPR vector
// -----------------------------------------------------------------------------
package gpr_scoreboard_pkg;

  localparam int NUM_GPR   = 32;
  localparam int GPR_IDX_W = 5;
  localparam int NUM_CR    = 8;
  localparam int DEF_CNT_W = 32;

  typedef logic [GPR_IDX_W-1:0] reg_index_t;

  typedef enum logic {
    SB_RUN   = 1'b0,
    SB_DRAIN = 1'b1
  } sb_state_e;

  // Single-bit special purpose registers share one pending vector.
  localparam int SPR_CTR = 0;
  localparam int SPR_LNK = 1;
  localparam int SPR_XER = 2;
  localparam int NUM_SPR = 3;

  // Pack the three SPR flags into the SPR vector layout.
  function automatic logic [NUM_SPR-1:0] spr_vec(input logic ctr,
                                                 input logic lnk,
                                                 input logic xer);
    logic [NUM_SPR-1:0] v;
    v          = '0;
    v[SPR_CTR] = ctr;
    v[SPR_LNK] = lnk;
    v[SPR_XER] = xer;
    return v;
  endfunction

endpackage

// File: rtl/gpr_scoreboard_pend_vec.sv
// -----------------------------------------------------------------------------
// gpr_scoreboard_pend_vec
// Pending-bit vector. Bits are set by up to two indexed producers and/or a
// set mask, and cleared by up to two indexed writebacks and/or a clear mask.
// When a bit is set and cleared in the same cycle the set wins, so a new
// producer stays pending even if an older write to the same bit retires.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   i_set_a_vld/idx, i_set_b_* : indexed set requests
//   i_clr_a_vld/idx, i_clr_b_* : indexed clear requests (equal indices = one clear)
//   i_set_mask, i_clr_mask     : mask-style set/clear (CR fields, SPRs)
//   o_pend                     : registered pending vector
// -----------------------------------------------------------------------------
module gpr_scoreboard_pend_vec #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_set_a_vld,
  input  logic [IDX_W-1:0] i_set_a_idx,
  input  logic             i_set_b_vld,
  input  logic [IDX_W-1:0] i_set_b_idx,
  input  logic             i_clr_a_vld,
  input  logic [IDX_W-1:0] i_clr_a_idx,
  input  logic             i_clr_b_vld,
  input  logic [IDX_W-1:0] i_clr_b_idx,
  input  logic [WIDTH-1:0] i_set_mask,
  input  logic [WIDTH-1:0] i_clr_mask,
  output logic [WIDTH-1:0] o_pend
);

  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] r_pend;

  // Per-bit decode of the indexed requests merged with the masks.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_set[gi] = i_set_mask[gi]
                       | (i_set_a_vld && (i_set_a_idx == IDX_W'(gi)))
                       | (i_set_b_vld && (i_set_b_idx == IDX_W'(gi)));
      assign w_clr[gi] = i_clr_mask[gi]
                       | (i_clr_a_vld && (i_clr_a_idx == IDX_W'(gi)))
                       | (i_clr_b_vld && (i_clr_b_idx == IDX_W'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      // Clear first, then OR in the sets: set wins on collision.
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/gpr_scoreboard.sv
// -----------------------------------------------------------------------------
// gpr_scoreboard
// Data hazard controller between decode and operand fetch/issue. Tracks
// in-flight writes to GPRs, CR fields, CTR, LNK and XER; blocks issue on RAW
// and WAW conflicts; releases entries on ALU/memory writeback. Also provides a
// drain handshake and a saturating stall-cycle counter.
// Ports:
//   clk, reset (async, active low)
//   en                          : gate for issue inputs
//   issue_valid / issue_ready   : decode handshake (ready is combinational)
//   gpr_a/b/c, read_gpr_a/b/c   : GPR sources
//   gpr_dest_alu/mem, write_*   : GPR destinations
//   read_cr, write_cr           : CR field masks
//   read/write_ctr/lnk/xer      : SPR usage
//   wb_alu_*, wb_mem_*, wb_cr, wb_ctr/lnk/xer : writeback releases
//   drain_req / drain_ack       : drain handshake
//   busy                        : any resource pending
//   stall_cycles                : saturating count of stalled issue cycles
// -----------------------------------------------------------------------------
module gpr_scoreboard
  import gpr_scoreboard_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [GPR_IDX_W-1:0] gpr_a,
  input  logic [GPR_IDX_W-1:0] gpr_b,
  input  logic [GPR_IDX_W-1:0] gpr_c,
  input  logic                 read_gpr_a,
  input  logic                 read_gpr_b,
  input  logic                 read_gpr_c,
  input  logic [GPR_IDX_W-1:0] gpr_dest_alu,
  input  logic [GPR_IDX_W-1:0] gpr_dest_mem,
  input  logic                 write_gpr_dest_alu,
  input  logic                 write_gpr_dest_mem,
  input  logic [NUM_CR-1:0]    read_cr,
  input  logic [NUM_CR-1:0]    write_cr,
  input  logic                 read_ctr,
  input  logic                 write_ctr,
  input  logic                 read_lnk,
  input  logic                 write_lnk,
  input  logic                 read_xer,
  input  logic                 write_xer,
  input  logic                 wb_alu_valid,
  input  logic [GPR_IDX_W-1:0] wb_alu_idx,
  input  logic                 wb_mem_valid,
  input  logic [GPR_IDX_W-1:0] wb_mem_idx,
  input  logic [NUM_CR-1:0]    wb_cr,
  input  logic                 wb_ctr,
  input  logic                 wb_lnk,
  input  logic                 wb_xer,
  input  logic                 drain_req,
  output logic                 drain_ack,
  output logic                 busy,
  output logic [CNT_W-1:0]     stall_cycles
);

  logic [NUM_GPR-1:0] w_gpr_pend;
  logic [NUM_CR-1:0]  w_cr_pend;
  logic [NUM_SPR-1:0] w_spr_pend;

  logic [NUM_SPR-1:0] w_spr_use;
  logic [NUM_SPR-1:0] w_spr_wr;
  logic [NUM_SPR-1:0] w_spr_wb;

  logic w_raw_gpr;
  logic w_waw_gpr;
  logic w_cr_haz;
  logic w_spr_haz;
  logic w_hazard;
  logic w_issue_fire;
  logic w_stall;
  logic w_wb_idle;

  sb_state_e        r_state;
  logic             r_drain_ack;
  logic [CNT_W-1:0] r_stall_cnt;

  // ---------------------------------------------------------------------------
  // Hazard detection against registered pending state only: a resource freed
  // by a writeback this cycle becomes usable on the next cycle.
  // ---------------------------------------------------------------------------
  assign w_spr_use = spr_vec(read_ctr | write_ctr,
                             read_lnk | write_lnk,
                             read_xer | write_xer);
  assign w_spr_wr  = spr_vec(write_ctr, write_lnk, write_xer);
  assign w_spr_wb  = spr_vec(wb_ctr, wb_lnk, wb_xer);

  assign w_raw_gpr = (read_gpr_a & w_gpr_pend[gpr_a])
                   | (read_gpr_b & w_gpr_pend[gpr_b])
                   | (read_gpr_c & w_gpr_pend[gpr_c]);
  assign w_waw_gpr = (write_gpr_dest_alu & w_gpr_pend[gpr_dest_alu])
                   | (write_gpr_dest_mem & w_gpr_pend[gpr_dest_mem]);
  assign w_cr_haz  = (|(read_cr & w_cr_pend)) | (|(write_cr & w_cr_pend));
  assign w_spr_haz = |(w_spr_use & w_spr_pend);
  assign w_hazard  = w_raw_gpr | w_waw_gpr | w_cr_haz | w_spr_haz;

  assign issue_ready  = en & (r_state == SB_RUN) & ~w_hazard;
  assign w_issue_fire = issue_valid & issue_ready;
  // Drain-blocked cycles count too, but only while an enabled request is present.
  assign w_stall      = issue_valid & en & ~issue_ready;

  // ---------------------------------------------------------------------------
  // Pending vectors. GPRs use the indexed ports; CR and SPRs use masks.
  // ---------------------------------------------------------------------------
  gpr_scoreboard_pend_vec #(
    .WIDTH (NUM_GPR),
    .IDX_W (GPR_IDX_W)
  ) u_gpr_pend (
    .clk         (clk),
    .rst_n       (reset),
    .i_set_a_vld (w_issue_fire & write_gpr_dest_alu),
    .i_set_a_idx (gpr_dest_alu),
    .i_set_b_vld (w_issue_fire & write_gpr_dest_mem),
    .i_set_b_idx (gpr_dest_mem),
    .i_clr_a_vld (wb_alu_valid),
    .i_clr_a_idx (wb_alu_idx),
    .i_clr_b_vld (wb_mem_valid),
    .i_clr_b_idx (wb_mem_idx),
    .i_set_mask  ('0),
    .i_clr_mask  ('0),
    .o_pend      (w_gpr_pend)
  );

  gpr_scoreboard_pend_vec #(
    .WIDTH (NUM_CR),
    .IDX_W ($clog2(NUM_CR))
  ) u_cr_pend (
    .clk         (clk),
    .rst_n       (reset),
    .i_set_a_vld (1'b0),
    .i_set_a_idx ('0),
    .i_set_b_vld (1'b0),
    .i_set_b_idx ('0),
    .i_clr_a_vld (1'b0),
    .i_clr_a_idx ('0),
    .i_clr_b_vld (1'b0),
    .i_clr_b_idx ('0),
    .i_set_mask  (w_issue_fire ? write_cr : '0),
    .i_clr_mask  (wb_cr),
    .o_pend      (w_cr_pend)
  );

  gpr_scoreboard_pend_vec #(
    .WIDTH (NUM_SPR),
    .IDX_W (2)
  ) u_spr_pend (
    .clk         (clk),
    .rst_n       (reset),
    .i_set_a_vld (1'b0),
    .i_set_a_idx ('0),
    .i_set_b_vld (1'b0),
    .i_set_b_idx ('0),
    .i_clr_a_vld (1'b0),
    .i_clr_a_idx ('0),
    .i_clr_b_vld (1'b0),
    .i_clr_b_idx ('0),
    .i_set_mask  (w_issue_fire ? w_spr_wr : '0),
    .i_clr_mask  (w_spr_wb),
    .o_pend      (w_spr_pend)
  );

  assign busy = (|w_gpr_pend) | (|w_cr_pend) | (|w_spr_pend);

  // ---------------------------------------------------------------------------
  // Drain FSM. drain_ack is registered, so it rises one cycle after busy
  // falls and drops on the same edge that returns the FSM to RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= SB_RUN;
      r_drain_ack <= 1'b0;
    end else begin
      case (r_state)
        SB_RUN: begin
          r_drain_ack <= 1'b0;
          if (drain_req) begin
            r_state <= SB_DRAIN;
          end
        end
        SB_DRAIN: begin
          if (!drain_req) begin
            r_state     <= SB_RUN;
            r_drain_ack <= 1'b0;
          end else begin
            r_drain_ack <= ~busy;
          end
        end
        default: begin
          r_state     <= SB_RUN;
          r_drain_ack <= 1'b0;
        end
      endcase
    end
  end

  assign drain_ack = r_drain_ack;

  // Saturating stall counter: holds at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cnt;

  // ---------------------------------------------------------------------------
  // Simulation checks. A dual-destination collision is a decode bug (the RTL
  // still just sets the single bit). A writeback to an idle resource is
  // harmless but usually points at a stale or duplicated writeback.
  // ---------------------------------------------------------------------------
  assign w_wb_idle = (wb_alu_valid & ~w_gpr_pend[wb_alu_idx])
                   | (wb_mem_valid & ~w_gpr_pend[wb_mem_idx])
                   | (|(wb_cr & ~w_cr_pend))
                   | (|(w_spr_wb & ~w_spr_pend));

  a_dual_dest : assert property (@(posedge clk) disable iff (!reset)
      !(w_issue_fire && write_gpr_dest_alu && write_gpr_dest_mem &&
        (gpr_dest_alu == gpr_dest_mem)))
    else $error("gpr_scoreboard: ALU and MEM destinations name the same GPR");

  a_wb_idle : assert property (@(posedge clk) disable iff (!reset) !w_wb_idle)
    else $warning("gpr_scoreboard: writeback to a resource with no pending write");

endmodule

// File: tb/tb_gpr_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_gpr_scoreboard
// Directed testbench for gpr_scoreboard. A second instance with a 3-bit stall
// counter shares all stimulus so counter saturation is observable.
// -----------------------------------------------------------------------------
module tb_gpr_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       issue_valid;
  logic [4:0] gpr_a, gpr_b, gpr_c;
  logic       read_gpr_a, read_gpr_b, read_gpr_c;
  logic [4:0] gpr_dest_alu, gpr_dest_mem;
  logic       write_gpr_dest_alu, write_gpr_dest_mem;
  logic [7:0] read_cr, write_cr;
  logic       read_ctr, write_ctr, read_lnk, write_lnk, read_xer, write_xer;
  logic       wb_alu_valid, wb_mem_valid;
  logic [4:0] wb_alu_idx, wb_mem_idx;
  logic [7:0] wb_cr;
  logic       wb_ctr, wb_lnk, wb_xer;
  logic       drain_req;

  logic        issue_ready, drain_ack, busy;
  logic [31:0] stall_cycles;
  logic        s_ready, s_ack, s_busy;
  logic [2:0]  s_stall;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gpr_scoreboard dut (
    .clk(clk), .reset(reset), .en(en),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .gpr_a(gpr_a), .gpr_b(gpr_b), .gpr_c(gpr_c),
    .read_gpr_a(read_gpr_a), .read_gpr_b(read_gpr_b), .read_gpr_c(read_gpr_c),
    .gpr_dest_alu(gpr_dest_alu), .gpr_dest_mem(gpr_dest_mem),
    .write_gpr_dest_alu(write_gpr_dest_alu), .write_gpr_dest_mem(write_gpr_dest_mem),
    .read_cr(read_cr), .write_cr(write_cr),
    .read_ctr(read_ctr), .write_ctr(write_ctr),
    .read_lnk(read_lnk), .write_lnk(write_lnk),
    .read_xer(read_xer), .write_xer(write_xer),
    .wb_alu_valid(wb_alu_valid), .wb_alu_idx(wb_alu_idx),
    .wb_mem_valid(wb_mem_valid), .wb_mem_idx(wb_mem_idx),
    .wb_cr(wb_cr), .wb_ctr(wb_ctr), .wb_lnk(wb_lnk), .wb_xer(wb_xer),
    .drain_req(drain_req), .drain_ack(drain_ack), .busy(busy),
    .stall_cycles(stall_cycles)
  );

  gpr_scoreboard #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .en(en),
    .issue_valid(issue_valid), .issue_ready(s_ready),
    .gpr_a(gpr_a), .gpr_b(gpr_b), .gpr_c(gpr_c),
    .read_gpr_a(read_gpr_a), .read_gpr_b(read_gpr_b), .read_gpr_c(read_gpr_c),
    .gpr_dest_alu(gpr_dest_alu), .gpr_dest_mem(gpr_dest_mem),
    .write_gpr_dest_alu(write_gpr_dest_alu), .write_gpr_dest_mem(write_gpr_dest_mem),
    .read_cr(read_cr), .write_cr(write_cr),
    .read_ctr(read_ctr), .write_ctr(write_ctr),
    .read_lnk(read_lnk), .write_lnk(write_lnk),
    .read_xer(read_xer), .write_xer(write_xer),
    .wb_alu_valid(wb_alu_valid), .wb_alu_idx(wb_alu_idx),
    .wb_mem_valid(wb_mem_valid), .wb_mem_idx(wb_mem_idx),
    .wb_cr(wb_cr), .wb_ctr(wb_ctr), .wb_lnk(wb_lnk), .wb_xer(wb_xer),
    .drain_req(drain_req), .drain_ack(s_ack), .busy(s_busy),
    .stall_cycles(s_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[%0t] FAIL %s: got %0h expected %0h", $time, tag, got, exp);
    end else begin
      $display("[%0t] check %s: got %0h ok", $time, tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    issue_valid = 0;
    gpr_a = 0; gpr_b = 0; gpr_c = 0;
    read_gpr_a = 0; read_gpr_b = 0; read_gpr_c = 0;
    gpr_dest_alu = 0; gpr_dest_mem = 0;
    write_gpr_dest_alu = 0; write_gpr_dest_mem = 0;
    read_cr = 0; write_cr = 0;
    read_ctr = 0; write_ctr = 0; read_lnk = 0; write_lnk = 0;
    read_xer = 0; write_xer = 0;
    wb_alu_valid = 0; wb_alu_idx = 0; wb_mem_valid = 0; wb_mem_idx = 0;
    wb_cr = 0; wb_ctr = 0; wb_lnk = 0; wb_xer = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 0; en = 1; drain_req = 0;
    idle();
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(drain_ack), 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_ready", 32'(issue_ready), 1);
    @(negedge clk);
    reset = 1;
    tick();

    // ---- RAW on r3 ---------------------------------------------------------
    issue_valid = 1; write_gpr_dest_alu = 1; gpr_dest_alu = 3;
    settle(); chk("wr_r3_ready", 32'(issue_ready), 1);
    tick(); idle(); settle();
    chk("wr_r3_busy", 32'(busy), 1);
    issue_valid = 1; read_gpr_a = 1; gpr_a = 3;
    settle(); chk("raw_r3_ready", 32'(issue_ready), 0);
    tick(); chk("raw_stall1", stall_cycles, 1);
    tick(); chk("raw_stall2", stall_cycles, 2);
    wb_alu_valid = 1; wb_alu_idx = 3;
    settle(); chk("raw_no_bypass", 32'(issue_ready), 0);
    tick(); chk("raw_stall3", stall_cycles, 3);
    chk("sat_stall3", 32'(s_stall), 3);
    wb_alu_valid = 0;
    settle(); chk("raw_released", 32'(issue_ready), 1);
    chk("raw_busy0", 32'(busy), 0);
    tick(); idle(); settle();
    chk("raw_issued_stall", stall_cycles, 3);

    // ---- WAW on r5 (mem then alu), unrelated r6 read ------------------------
    issue_valid = 1; write_gpr_dest_mem = 1; gpr_dest_mem = 5;
    settle(); chk("ld_r5_ready", 32'(issue_ready), 1);
    tick(); idle();
    issue_valid = 1; write_gpr_dest_alu = 1; gpr_dest_alu = 5;
    settle(); chk("waw_r5_ready", 32'(issue_ready), 0);
    tick(); chk("waw_stall", stall_cycles, 4);
    idle(); issue_valid = 1; read_gpr_a = 1; gpr_a = 6;
    settle(); chk("r6_ready", 32'(issue_ready), 1);
    tick(); chk("r6_no_stall", stall_cycles, 4);
    idle(); issue_valid = 1; write_gpr_dest_alu = 1; gpr_dest_alu = 5;
    wb_mem_valid = 1; wb_mem_idx = 5;
    settle(); chk("waw_wb_same_cycle", 32'(issue_ready), 0);
    tick(); chk("waw_stall2", stall_cycles, 5);
    wb_mem_valid = 0;
    settle(); chk("waw_released", 32'(issue_ready), 1);
    tick(); idle(); settle();
    chk("alu_r5_busy", 32'(busy), 1);
    wb_alu_valid = 1; wb_alu_idx = 5;
    tick(); idle(); settle();
    chk("r5_cleared", 32'(busy), 0);

    // ---- Set wins over a same-cycle clear on r7 ----------------------------
    issue_valid = 1; write_gpr_dest_alu = 1; gpr_dest_alu = 7;
    wb_alu_valid = 1; wb_alu_idx = 7;
    settle(); chk("r7_ready", 32'(issue_ready), 1);
    tick(); idle(); settle();
    chk("setwin_busy", 32'(busy), 1);
    issue_valid = 1; read_gpr_b = 1; gpr_b = 7;
    settle(); chk("setwin_r7_pending", 32'(issue_ready), 0);
    idle(); wb_alu_valid = 1; wb_alu_idx = 7;
    tick(); idle(); settle();
    chk("r7_cleared", 32'(busy), 0);

    // ---- Equal ALU/MEM writeback indices: single clear ---------------------
    issue_valid = 1; write_gpr_dest_mem = 1; gpr_dest_mem = 9;
    tick(); idle();
    wb_alu_valid = 1; wb_alu_idx = 9; wb_mem_valid = 1; wb_mem_idx = 9;
    tick(); idle(); settle();
    chk("dual_wb_r9", 32'(busy), 0);

    // ---- CR field and CTR --------------------------------------------------
    issue_valid = 1; write_cr = 8'h80; write_ctr = 1;
    settle(); chk("cr_ctr_wr_ready", 32'(issue_ready), 1);
    tick(); idle();
    issue_valid = 1; read_cr = 8'h01;
    settle(); chk("cr01_ready", 32'(issue_ready), 1);
    tick(); idle();
    issue_valid = 1; read_cr = 8'h80;
    settle(); chk("cr80_ready", 32'(issue_ready), 0);
    tick(); chk("cr80_stall", stall_cycles, 6);
    idle(); issue_valid = 1; read_ctr = 1;
    settle(); chk("bdnz_blocked", 32'(issue_ready), 0);
    idle(); wb_cr = 8'h80; wb_ctr = 1;
    tick(); idle();
    issue_valid = 1; read_ctr = 1; read_cr = 8'h80;
    settle(); chk("bdnz_ready", 32'(issue_ready), 1);
    tick(); idle(); settle();
    chk("cr_ctr_busy0", 32'(busy), 0);

    // ---- LNK and XER -------------------------------------------------------
    issue_valid = 1; write_lnk = 1; write_xer = 1;
    tick(); idle();
    issue_valid = 1; read_lnk = 1;
    settle(); chk("lnk_blocked", 32'(issue_ready), 0);
    idle(); issue_valid = 1; read_xer = 1;
    settle(); chk("xer_blocked", 32'(issue_ready), 0);
    idle(); wb_lnk = 1; wb_xer = 1;
    tick(); idle(); settle();
    chk("lnk_xer_busy0", 32'(busy), 0);
    chk("spr_stall_hold", stall_cycles, 6);

    // ---- Drain -------------------------------------------------------------
    issue_valid = 1; write_gpr_dest_alu = 1; gpr_dest_alu = 10;
    write_gpr_dest_mem = 1; gpr_dest_mem = 11;
    settle(); chk("drain_pre_ready", 32'(issue_ready), 1);
    tick(); idle();
    drain_req = 1;
    tick();
    issue_valid = 1; read_gpr_a = 1; gpr_a = 1;
    settle(); chk("drain_ready0", 32'(issue_ready), 0);
    tick(); chk("drain_stall", stall_cycles, 7);
    chk("sat_stall7", 32'(s_stall), 7);
    idle(); wb_alu_valid = 1; wb_alu_idx = 10;
    tick(); idle(); settle();
    chk("drain_busy1", 32'(busy), 1);
    chk("drain_ack0a", 32'(drain_ack), 0);
    wb_mem_valid = 1; wb_mem_idx = 11;
    tick(); idle(); settle();
    chk("drain_busy0", 32'(busy), 0);
    chk("drain_ack0b", 32'(drain_ack), 0);
    tick();
    chk("drain_ack1", 32'(drain_ack), 1);
    drain_req = 0;
    settle(); chk("drain_still_blocked", 32'(issue_ready), 0);
    tick();
    chk("run_ack0", 32'(drain_ack), 0);
    chk("run_ready", 32'(issue_ready), 1);

    // ---- en = 0: no issue, no stall, writebacks still processed ------------
    issue_valid = 1; write_gpr_dest_alu = 1; gpr_dest_alu = 12;
    tick(); idle();
    en = 0;
    issue_valid = 1; read_gpr_a = 1; gpr_a = 12;
    settle(); chk("en0_ready", 32'(issue_ready), 0);
    tick(); chk("en0_no_stall", stall_cycles, 7);
    idle(); issue_valid = 1; write_gpr_dest_alu = 1; gpr_dest_alu = 13;
    wb_alu_valid = 1; wb_alu_idx = 12;
    tick(); idle(); settle();
    chk("en0_wb_no_issue", 32'(busy), 0);
    en = 1;

    // ---- Saturation and asynchronous reset mid-stall -----------------------
    issue_valid = 1; write_gpr_dest_alu = 1; gpr_dest_alu = 3;
    tick(); idle();
    issue_valid = 1; read_gpr_a = 1; gpr_a = 3;
    settle(); chk("rst_pre_ready", 32'(issue_ready), 0);
    tick(); chk("pre_rst_stall", stall_cycles, 8);
    chk("sat_hold7", 32'(s_stall), 7);
    chk("sat_busy", 32'(s_busy), 1);
    #2 reset = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_stall", stall_cycles, 0);
    chk("arst_sat_stall", 32'(s_stall), 0);
    chk("arst_ack", 32'(drain_ack), 0);
    chk("arst_ready", 32'(issue_ready), 1);
    chk("arst_sat_ready", 32'(s_ready), 1);
    chk("arst_sat_ack", 32'(s_ack), 0);
    @(negedge clk);
    reset = 1;
    tick(); idle(); settle();
    chk("post_rst_issue_stall", stall_cycles, 0);
    chk("post_rst_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gpr_scoreboard.md
Name: gpr_scoreboard

Overview:
- Scoreboard-based data hazard controller. It sits between decode and operand fetch/issue.
- It consumes the decoded read/write register sets of the instruction at issue and tracks in-flight writes to GPRs, CR fields, CTR, LNK and XER.
- It blocks issue on RAW and WAW conflicts and releases entries on writeback from the ALU and memory paths.
- It also provides a pipeline drain handshake and a stall-cycle counter.

Parameters:
- NUM_GPR, 32, number of general purpose registers tracked.
- GPR_IDX_W, 5, width of a GPR index (clog2 NUM_GPR).
- NUM_CR, 8, number of CR fields tracked.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  when 0, issue inputs are ignored; no issue, no stall.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  instruction may issue this cycle (combinational).
- gpr_a, gpr_b, gpr_c  in  GPR_IDX_W  source indices.
- read_gpr_a, read_gpr_b, read_gpr_c  in  1  source valid flags.
- gpr_dest_alu, gpr_dest_mem  in  GPR_IDX_W  destination indices.
- write_gpr_dest_alu, write_gpr_dest_mem  in  1  destination valid flags.
- read_cr  in  NUM_CR  OR of the three CR read masks.
- write_cr  in  NUM_CR  CR fields written.
- read_ctr, write_ctr, read_lnk, write_lnk, read_xer, write_xer  in  1  SPR use flags.
- wb_alu_valid  in  1  ALU GPR writeback.
- wb_alu_idx  in  GPR_IDX_W  ALU writeback index.
- wb_mem_valid  in  1  memory GPR writeback.
- wb_mem_idx  in  GPR_IDX_W  memory writeback index.
- wb_cr  in  NUM_CR  CR fields written back.
- wb_ctr, wb_lnk, wb_xer  in  1  SPR writebacks.
- drain_req  in  1  request to empty the scoreboard.
- drain_ack  out  1  scoreboard empty while draining.
- busy  out  1  any pending bit set.
- stall_cycles  out  CNT_W  count of cycles with issue_valid & en & !issue_ready.

Behaviour:
- State: gpr_pend[NUM_GPR], cr_pend[NUM_CR], ctr_pend, lnk_pend, xer_pend, and an FSM {RUN, DRAIN}.
- Reset: all pending bits 0, FSM=RUN, stall_cycles=0, drain_ack=0, busy=0. issue_ready follows its combinational definition from the reset state.
- hazard = any(read_gpr_x & gpr_pend[gpr_x]) | (write_gpr_dest_alu & gpr_pend[gpr_dest_alu]) | (write_gpr_dest_mem & gpr_pend[gpr_dest_mem]) | |(read_cr & cr_pend) | |(write_cr & cr_pend) | ((read_ctr|write_ctr) & ctr_pend), and the same for LNK and XER.
- The hazard check uses registered pending state only. There is no same-cycle writeback bypass, so a register freed in cycle N can be consumed in cycle N+1.
- issue_ready = en & (FSM==RUN) & !hazard. issue fires when issue_valid & issue_ready.
- On issue, pending bits for all written resources are set, effective next edge.
- Writebacks clear the addressed bits, effective next edge.
- Set and clear of the same bit in the same cycle: the set wins, so the new producer remains pending.
- wb_alu_idx == wb_mem_idx in one cycle: a single clear.
- write_gpr_dest_alu & write_gpr_dest_mem with equal indices is illegal. A simulation assertion flags it. RTL sets the single bit.
- A writeback to a non-pending bit is a no-op. It is flagged by a warning assertion only.
- en=0: no issue and no stall count. Writebacks are still processed.
- FSM:
  - RUN -> DRAIN on drain_req.
  - In DRAIN, issue_ready=0. drain_ack = !busy, registered (asserted the cycle after busy falls).
  - DRAIN -> RUN when drain_req deasserts; drain_ack then drops in the same edge.
- busy = OR of all pending bits, registered view.
- stall_cycles increments by 1 per stalled cycle and saturates at all-ones (no wrap).
- Stalls caused by DRAIN count only when issue_valid & en.
- Reset mid-operation: all pending state is discarded immediately (asynchronous), and in-flight writebacks after reset are no-ops.

Decomposition:
- Pu_types supplies Reg_index. Add a shared package constant for NUM_CR and a Sb_state enum {SB_RUN, SB_DRAIN}.
- One natural sub-module, pend_vec: a parameterized pending bit vector with set-index/clear-index ports and the set-wins rule. It is instantiated for GPRs; CR and the SPRs use the mask variant.

Test Plan:
- Reset, then issue an instruction writing r3 via ALU → gpr_pend[3]=1, busy=1. A next instruction reading r3 gets issue_ready=0 and stall_cycles increments each cycle. Assert wb_alu_valid idx=3 → ready=1 on the following cycle, not the same one.
- Load writes r5 (mem) and a second instruction writes r5 (ALU) → WAW stall until wb_mem idx=5. An unrelated read of r6 issues without stall.
- Same-cycle issue writing r7 and wb_alu idx=7 (from an older write) → gpr_pend[7] stays 1.
- Issue write_cr=8'h80 and write_ctr; a reader with read_cr=8'h01 issues, a reader with read_cr=8'h80 stalls; wb_cr=8'h80 and wb_ctr clear both; a bdnz reading ctr then issues.
- drain_req with 2 pending writes → issue_ready=0; drain_ack rises 1 cycle after the last writeback; drop drain_req → RUN and drain_ack=0.
- Assert reset low mid-stall with r3 pending → all outputs go to reset values asynchronously. After release, a read of r3 issues immediately.
